serial_rx: RTL and testbench

Receiver counterpart of the serial transmitter: deserializes an MSB-first data word from a single-bit line, driven by the same shared `cnt` timebase and the same `n0`/`n1`/`nbits` framing parameters. It sits at the far end of a point-to-point serial link, with `x` wired directly to the transmitter's `y`. It samples each bit at its midpoint and presents the assembled word with a one-cycle valid pulse.

---
 rtl/serial_rx.sv | 135 +++++++++++++
 tb/tb_serial_rx.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
// serial_rx: midpoint-sampling MSB-first deserializer on shared cnt timebase; optional idle check via SERIAL_RX_IDLE_CHK_EN.
// data/valid appear one cycle after the last-bit sample edge; no backpressure (valid is a single-cycle pulse).
module serial_rx #(
    parameter int P_DATA_WIDTH = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    x,
    input  logic                    y0,
    input  logic [7:0]              nbits,
    input  logic [31:0]             n0,
    input  logic [31:0]             n1,
    input  logic [31:0]             cnt,
    output logic [P_DATA_WIDTH-1:0] data,
    output logic                    valid,
    output logic                    busy
`ifdef SERIAL_RX_IDLE_CHK_EN
    ,
    output logic                    err
`endif
);

    typedef enum logic [0:0] {S_ARM, S_RX} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             t_q, t_d;
    logic [31:0]             n1_q, n1_d;
    logic [7:0]              nb_q, nb_d;
    logic [7:0]              bit_q, bit_d;
    // The MSB of the shift register is never read, so only the low W-1 bits are stored.
    logic [P_DATA_WIDTH-2:0] sr_q, sr_d;
    logic [P_DATA_WIDTH-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;

    logic [31:0] i_n0, i_n1, h;
    logic [7:0]  i_nb;

    assign i_n0 = (n0 == 32'd0) ? 32'd1 : n0;
    assign i_n1 = (n1 == 32'd0) ? 32'd1 : n1;
    assign i_nb = (nbits == 8'd0) ? 8'd1 : nbits;
    // (i_n1+1)>>1 without a 33-bit intermediate: floor half plus the dropped LSB.
    assign h    = {1'b0, i_n1[31:1]} + {31'd0, i_n1[0]};

`ifdef SERIAL_RX_IDLE_CHK_EN
    logic ferr_q, ferr_d;
    assign err = valid_q & ferr_q;
`else
    logic unused_y0;
    assign unused_y0 = y0;
`endif

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        n1_d    = n1_q;
        nb_d    = nb_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
`ifdef SERIAL_RX_IDLE_CHK_EN
        ferr_d  = ferr_q;
`endif
        case (state_q)
            S_ARM: begin
                if (cnt == i_n0) begin
                    n1_d    = i_n1;
                    nb_d    = i_nb;
                    t_d     = i_n0 + h;
                    sr_d    = '0;
                    bit_d   = 8'd0;
                    busy_d  = 1'b1;
                    state_d = S_RX;
`ifdef SERIAL_RX_IDLE_CHK_EN
                    ferr_d  = (x != y0);
`endif
                end
            end
            S_RX: begin
                if (cnt == t_q) begin
                    sr_d  = {sr_q[P_DATA_WIDTH-3:0], x};
                    bit_d = bit_q + 8'd1;
                    t_d   = t_q + n1_q;
                    if (bit_q == nb_q - 8'd1) begin
                        data_d  = {sr_q, x};
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_ARM;
                    end
                end
            end
            default: begin
                state_d = S_ARM;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_ARM;
            t_q     <= '0;
            n1_q    <= '0;
            nb_q    <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SERIAL_RX_IDLE_CHK_EN
            ferr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            n1_q    <= n1_d;
            nb_q    <= nb_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
`ifdef SERIAL_RX_IDLE_CHK_EN
            ferr_q  <= ferr_d;
`endif
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: drives cnt and an ideal transmitter line, and checks valid/busy/data (and err) every cycle.
module tb_serial_rx;
    localparam int W = 256;

    logic          clk = 1'b0;
    logic          rst, x, y0;
    logic [7:0]    nbits;
    logic [31:0]   n0, n1, cnt;
    logic [W-1:0]  data;
    logic          valid, busy;
`ifdef SERIAL_RX_IDLE_CHK_EN
    logic          err;
`endif

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] exp_data;

    always #5 clk = ~clk;

    serial_rx #(.P_DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .x     (x),
        .y0    (y0),
        .nbits (nbits),
        .n0    (n0),
        .n1    (n1),
        .cnt   (cnt),
        .data  (data),
        .valid (valid),
        .busy  (busy)
`ifdef SERIAL_RX_IDLE_CHK_EN
        ,
        .err   (err)
`endif
    );

    task automatic check1(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // One frame: cnt runs from i_n0-3 upward, the line follows the transmitter timing
    // (bit k driven from the edge at cnt == n0 + k*n1). abort_bits>0 resets after that many samples.
    task automatic run_frame(input logic [31:0] rn0, input logic [31:0] rn1, input logic [7:0] rnb,
                             input logic [W-1:0] word, input logic bad_idle, input int abort_bits);
        longint       en0, en1, enb, h, o_last, k;
        logic [W-1:0] expw;
        en0 = (rn0 == 32'd0) ? 1 : longint'(rn0);
        en1 = (rn1 == 32'd0) ? 1 : longint'(rn1);
        enb = (rnb == 8'd0)  ? 1 : longint'(rnb);
        h      = (en1 + 1) / 2;
        o_last = h + (enb - 1) * en1;
        expw = '0;
        for (int i = 0; i < enb; i++) expw[i] = word[i];
        n0 = rn0; n1 = rn1; nbits = rnb;
        for (longint o = -3; o <= o_last + 3; o++) begin
            cnt = 32'(en0 + o);
            if (o >= 1) begin
                k = (o - 1) / en1;
                x = (k < enb) ? word[int'(enb - 1 - k)] : y0;
            end else begin
                x = (o == 0 && bad_idle) ? ~y0 : y0;
            end
            @(posedge clk); #1;
            if (o == o_last) exp_data = expw;
            check1("valid", valid, (o == o_last) ? 1 : 0);
            check1("busy",  busy,  (o >= 0 && o < o_last) ? 1 : 0);
            check1("data",  data,  exp_data);
`ifdef SERIAL_RX_IDLE_CHK_EN
            check1("err",   err,   (o == o_last) ? bad_idle : 1'b0);
`endif
            if (abort_bits > 0 && o == h + (abort_bits - 1) * en1) begin
                rst = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
                exp_data = '0;
                check1("abort_valid", valid, 0);
                check1("abort_busy",  busy,  0);
                check1("abort_data",  data,  '0);
                return;
            end
        end
    endtask

    initial begin
        rst = 1'b0; x = 1'b1; y0 = 1'b1;
        n0 = 32'd4; n1 = 32'd4; nbits = 8'd8; cnt = 32'd0;
        exp_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check1("rst_valid", valid, 0);
        check1("rst_busy",  busy,  0);
        check1("rst_data",  data,  '0);
`ifdef SERIAL_RX_IDLE_CHK_EN
        check1("rst_err",   err,   0);
`endif
        rst = 1'b1;

        // Directed frames from the test plan.
        run_frame(32'd4, 32'd4, 8'd8,  W'(32'hA5),   1'b0, 0);
        run_frame(32'd1, 32'd1, 8'd16, W'(32'h8001), 1'b0, 0);
        run_frame(32'd0, 32'd0, 8'd0,  W'(32'h1),    1'b0, 0);
        run_frame(32'd4, 32'd4, 8'd8,  W'(32'h3C),   1'b0, 3);
        run_frame(32'd4, 32'd4, 8'd8,  W'(32'h3C),   1'b0, 0);
        run_frame(32'd4, 32'd4, 8'd8,  W'(32'h12),   1'b0, 0);
        run_frame(32'd4, 32'd4, 8'd8,  W'(32'hFE),   1'b0, 0);
        run_frame(32'hFFFF_FFFE, 32'd4, 8'd8, W'(32'h5B), 1'b0, 0);

        // Randomized frames, including an odd bit time and full 32-bit n0.
        for (int i = 0; i < 10; i++) begin
            y0 = 1'($urandom_range(0, 1));
            run_frame(32'($urandom_range(0, 1000)), 32'($urandom_range(0, 7)),
                      8'($urandom_range(0, 64)), rand_word(), 1'b0, 0);
        end
        run_frame($urandom, 32'($urandom_range(1, 3)), 8'd255, rand_word(), 1'b0, 0);
        y0 = 1'b1;
        run_frame(32'($urandom_range(2, 50)), 32'($urandom_range(1, 6)),
                  8'($urandom_range(2, 40)), rand_word(), 1'b0, 5);

`ifdef SERIAL_RX_IDLE_CHK_EN
        y0 = 1'b1;
        run_frame(32'd4, 32'd4, 8'd8, rand_word(), 1'b1, 0);
        run_frame(32'd4, 32'd4, 8'd8, rand_word(), 1'b0, 0);
        y0 = 1'b0;
        run_frame(32'd9, 32'd3, 8'd12, rand_word(), 1'b1, 0);
        run_frame(32'd9, 32'd3, 8'd12, rand_word(), 1'b0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
